// File: rtl/dg0045_rom_responder.sv
// ============================================================================
// Module      : dg0045_rom_responder
// Description : 1024x8 instruction ROM emulator that scans a multiplexed core
//               PC bus and serves the addressed byte, with a loader write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dg0045_rom_responder (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [4:0] pc_hl,
    output logic       pc_mux,
    output logic [7:0] rom_data,
    input  logic       load_valid,
    input  logic [9:0] load_addr,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic [9:0] addr_out,
    output logic       addr_valid
);

    typedef enum logic [2:0] {
        S_PARK   = 3'd0,
        S_SEL_LO = 3'd1,
        S_SMP_LO = 3'd2,
        S_SEL_HI = 3'd3,
        S_SMP_HI = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        pc_mux_q, pc_mux_d;
    logic [7:0]  rom_data_q, rom_data_d;
    logic [9:0]  addr_out_q, addr_out_d;
    logic        addr_valid_q, addr_valid_d;
    logic        load_ready_q, load_ready_d;
    logic [4:0]  lo_q, lo_d;
    logic        refresh_q, refresh_d;
    logic [7:0]  rd_q;
    logic [7:0]  mem [1024];

    logic        w_load_accept;
    logic [9:0]  w_rd_addr;

    assign w_load_accept = load_valid & load_ready_q;
    assign w_rd_addr     = {pc_hl, lo_q};

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        addr_out_d   = addr_out_q;
        addr_valid_d = addr_valid_q;
        rom_data_d   = rom_data_q;
        refresh_d    = 1'b0;
        load_ready_d = ~w_load_accept;

        case (state_q)
            S_PARK:   state_d = S_SEL_LO;
            S_SEL_LO: state_d = S_SMP_LO;
            S_SMP_LO: begin
                state_d = S_SEL_HI;
                lo_d    = pc_hl;
            end
            S_SEL_HI: state_d = S_SMP_HI;
            S_SMP_HI: begin
                state_d      = S_SEL_LO;
                addr_out_d   = w_rd_addr;
                addr_valid_d = 1'b1;
                refresh_d    = 1'b1;
            end
            default:  state_d = S_PARK;
        endcase

        // The byte read at SMP_HI lands on rom_data one clock later.
        if (refresh_q) begin
            rom_data_d = rd_q;
        end

        if (!run) begin
            state_d      = S_PARK;
            lo_d         = 5'd0;
            addr_valid_d = 1'b0;
            rom_data_d   = 8'h00;
            refresh_d    = 1'b0;
        end

        pc_mux_d = (state_d == S_SEL_HI) || (state_d == S_SMP_HI);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_PARK;
            pc_mux_q     <= 1'b0;
            rom_data_q   <= 8'h00;
            addr_out_q   <= 10'h000;
            addr_valid_q <= 1'b0;
            load_ready_q <= 1'b1;
            lo_q         <= 5'd0;
            refresh_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_mux_q     <= pc_mux_d;
            rom_data_q   <= rom_data_d;
            addr_out_q   <= addr_out_d;
            addr_valid_q <= addr_valid_d;
            load_ready_q <= load_ready_d;
            lo_q         <= lo_d;
            refresh_q    <= refresh_d;
        end
    end

    // Storage is not reset; a same-edge write is seen by the next read only.
    always_ff @(posedge clk) begin
        if (w_load_accept) begin
            mem[load_addr] <= load_data;
        end
        if (state_q == S_SMP_HI) begin
            rd_q <= mem[w_rd_addr];
        end
    end

    assign pc_mux     = pc_mux_q;
    assign rom_data   = rom_data_q;
    assign addr_out   = addr_out_q;
    assign addr_valid = addr_valid_q;
    assign load_ready = load_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_dg0045_rom_responder.sv
// ============================================================================
// Module      : tb_dg0045_rom_responder
// Description : Self-checking bench for dg0045_rom_responder with a core-side
//               PC model and a loader-side memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dg0045_rom_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [4:0] pc_hl;
    logic       pc_mux;
    logic [7:0] rom_data;
    logic       load_valid;
    logic [9:0] load_addr;
    logic [7:0] load_data;
    logic       load_ready;
    logic [9:0] addr_out;
    logic       addr_valid;

    logic [9:0] pc;
    logic [7:0] model_mem [1024];
    logic [9:0] written_q [$];
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    // Core presents {PU,PL[5]} when pc_mux=1, PL[4:0] otherwise.
    assign pc_hl = pc_mux ? pc[9:5] : pc[4:0];

    dg0045_rom_responder dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .pc_hl      (pc_hl),
        .pc_mux     (pc_mux),
        .rom_data   (rom_data),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .addr_out   (addr_out),
        .addr_valid (addr_valid)
    );

    task automatic wait_mux(input logic v, input string tag);
        int n = 0;
        @(negedge clk);
        while (pc_mux !== v && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (pc_mux !== v) begin
            total++;
            $display("FAIL %s timeout: pc_mux=%b required %b", tag, pc_mux, v);
        end
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d);
        total++;
        if (load_ready !== 1'b1) $display("FAIL wr_ready_pre: got %b required 1", load_ready);
        else passed++;
        load_valid = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_valid = 1'b0;
        model_mem[a] = d;
        written_q.push_back(a);
        total++;
        if (load_ready !== 1'b0) $display("FAIL wr_ready_low: got %b required 0", load_ready);
        else passed++;
        @(negedge clk);
    endtask

    task automatic settle_check(input logic [9:0] a, input string tag);
        pc = a;
        repeat (10) @(negedge clk);
        total++;
        if (rom_data !== model_mem[a]) $display("FAIL %s rom_data: got %h required %h", tag, rom_data, model_mem[a]);
        else passed++;
        total++;
        if (addr_out !== a || addr_valid !== 1'b1)
            $display("FAIL %s addr: got %h/%b required %h/1", tag, addr_out, addr_valid, a);
        else passed++;
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
        pc = 10'($urandom);
        repeat (2) @(negedge clk);
        total++;
        if (pc_mux !== 1'b0 || rom_data !== 8'h00) $display("FAIL reset_out: got mux=%b rom=%h required 0/00", pc_mux, rom_data);
        else passed++;
        total++;
        if (addr_valid !== 1'b0 || load_ready !== 1'b1 || addr_out !== 10'h000)
            $display("FAIL reset_flags: got av=%b lr=%b ao=%h required 0/1/000", addr_valid, load_ready, addr_out);
        else passed++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (pc_mux !== 1'b0 || rom_data !== 8'h00 || addr_valid !== 1'b0)
            $display("FAIL park_hold: got mux=%b rom=%h av=%b required 0/00/0", pc_mux, rom_data, addr_valid);
        else passed++;
    endtask

    task automatic test_load_and_run;
        do_write(10'h3FF, 8'hC5);
        do_write(10'h000, 8'h1B);
        pc  = 10'h3FF;
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            logic       exp_mux;
            logic [7:0] exp_rom;
            @(negedge clk);
            exp_mux = ((k - 1) % 4) >= 2;
            exp_rom = (k >= 6) ? 8'hC5 : 8'h00;
            total++;
            if (pc_mux !== exp_mux) $display("FAIL run_mux k=%0d: got %b required %b", k, pc_mux, exp_mux);
            else passed++;
            total++;
            if (rom_data !== exp_rom) $display("FAIL run_rom k=%0d: got %h required %h", k, rom_data, exp_rom);
            else passed++;
            if (k == 4 || k == 5) begin
                total++;
                if (addr_valid !== (k == 5)) $display("FAIL run_av k=%0d: got %b required %b", k, addr_valid, k == 5);
                else passed++;
            end
        end
        total++;
        if (addr_out !== 10'h3FF) $display("FAIL run_addr: got %h required 3ff", addr_out);
        else passed++;
    endtask

    task automatic test_pc_change;
        int first = 0;
        wait_mux(1'b1, "pcchg_hi");
        wait_mux(1'b0, "pcchg_lo");
        pc = 10'h000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (rom_data !== 8'hC5 && rom_data !== 8'h1B) $display("FAIL pcchg_value k=%0d: got %h required c5 or 1b", k, rom_data);
            else passed++;
            if (first == 0 && rom_data === 8'h1B) first = k;
        end
        total++;
        if (first == 0 || first > 6) $display("FAIL pcchg_latency: got %0d clk required 1..6", first);
        else passed++;
    endtask

    task automatic test_same_addr;
        settle_check(10'h3FF, "same_pre");
        wait_mux(1'b0, "same_lo");
        wait_mux(1'b1, "same_hi");
        @(negedge clk);
        load_valid = 1'b1; load_addr = 10'h3FF; load_data = 8'hA7;
        @(negedge clk);
        load_valid = 1'b0;
        model_mem[10'h3FF] = 8'hA7;
        total++;
        if (load_ready !== 1'b0) $display("FAIL same_ready_low: got %b required 0", load_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (load_ready !== 1'b1) $display("FAIL same_ready_back: got %b required 1", load_ready);
        else passed++;
        total++;
        if (rom_data !== 8'hC5) $display("FAIL same_old: got %h required c5", rom_data);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (rom_data !== 8'hC5) $display("FAIL same_hold: got %h required c5", rom_data);
        else passed++;
        @(negedge clk);
        total++;
        if (rom_data !== 8'hA7) $display("FAIL same_new: got %h required a7", rom_data);
        else passed++;
    endtask

    task automatic test_run_drop;
        wait_mux(1'b0, "drop_lo");
        wait_mux(1'b1, "drop_hi");
        run = 1'b0;
        @(negedge clk);
        total++;
        if (rom_data !== 8'h00 || pc_mux !== 1'b0 || addr_valid !== 1'b0)
            $display("FAIL drop_park: got rom=%h mux=%b av=%b required 00/0/0", rom_data, pc_mux, addr_valid);
        else passed++;
        repeat (2) @(negedge clk);
        run = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            logic [7:0] exp_rom;
            @(negedge clk);
            exp_rom = (k >= 6) ? model_mem[pc] : 8'h00;
            total++;
            if (rom_data !== exp_rom) $display("FAIL drop_rerun k=%0d: got %h required %h", k, rom_data, exp_rom);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] base;
        logic [7:0] d [6];
        base = 10'($urandom_range(1, 1000));
        for (int i = 1; i < 6; i += 2) do_write(base + 10'(i), 8'($urandom));
        for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            load_valid = 1'b1; load_addr = base + 10'(i); load_data = d[i];
            @(negedge clk);
            if (i % 2 == 0) model_mem[base + 10'(i)] = d[i];
            total++;
            if (load_ready !== (i % 2 != 0)) $display("FAIL b2b_ready i=%0d: got %b required %b", i, load_ready, i % 2 != 0);
            else passed++;
        end
        load_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) settle_check(base + 10'(i), "b2b_mem");
    endtask

    task automatic test_random;
        for (int it = 0; it < 16; it++) begin
            logic [9:0] a;
            a = 10'($urandom);
            do_write(a, 8'($urandom));
            if ($urandom_range(0, 1) == 1) a = written_q[$urandom_range(0, written_q.size() - 1)];
            settle_check(a, "rand");
        end
    endtask

    task automatic test_reset_keeps_mem;
        logic [9:0] a;
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        rst = 1'b1;
        #1;
        total++;
        if (pc_mux !== 1'b0 || rom_data !== 8'h00 || addr_valid !== 1'b0 || load_ready !== 1'b1 || addr_out !== 10'h000)
            $display("FAIL async_reset: got mux=%b rom=%h av=%b lr=%b ao=%h required 0/00/0/1/000",
                     pc_mux, rom_data, addr_valid, load_ready, addr_out);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        settle_check(a, "mem_kept");
    endtask

    initial begin
        test_reset();
        test_load_and_run();
        test_pc_change();
        test_same_addr();
        test_run_drop();
        test_back_to_back();
        test_random();
        test_reset_keeps_mem();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
